// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one single-port RAM between the stack CPU (default owner) and an external master with burst limiting.
// Ports: clk/reset (sync, active-high); run_en user run switch; cpu_haltN stall to CPU;
//   cpu_* CPU RAM request and read data; ext_req/ext_* external beat request, grant, registered read return;
//   ram_* muxed RAM interface (asynchronous read, write on posedge when ram_readWriteN=0).
module ram_bus_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_BURST = 4,
  parameter int CPU_SLOT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_en,
  output logic          cpu_haltN,
  input  logic          cpu_readWriteN,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_readWriteN,
  input  logic [AW-1:0] ext_address,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          ram_readWriteN,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  typedef enum logic [1:0] {CPU_OWN, EXT_OWN, CPU_GUARD} state_t;
  state_t state, state_nx;
  logic [7:0] beat_cnt, beat_nx, slot_cnt, slot_nx;
  logic beat, limit_hit, slot_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CPU_OWN;
      beat_cnt <= '0;
      slot_cnt <= '0;
    end else begin
      state <= state_nx;
      beat_cnt <= beat_nx;
      slot_cnt <= slot_nx;
    end
  end
  // The burst limit only applies while the CPU could actually use the freed slot.
  assign beat = ext_gnt & ext_req;
  assign limit_hit = beat & run_en & (MAX_BURST != 0) & (({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST));
  assign slot_done = ({1'b0, slot_cnt} + 9'd1) == 9'(CPU_SLOT);
  // The guard always returns to CPU_OWN, so a waiting master sees one extra CPU cycle of grant latency.
  always_comb begin
    state_nx = state;
    beat_nx = beat_cnt;
    slot_nx = slot_cnt;
    unique case (state)
      CPU_OWN:
        if (ext_req) begin
          state_nx = EXT_OWN;
          beat_nx = '0;
        end
      EXT_OWN:
        if (limit_hit) begin
          state_nx = CPU_GUARD;
          slot_nx = '0;
        end else if (!ext_req) state_nx = CPU_OWN;
        else beat_nx = beat_cnt + {7'd0, beat_cnt != 8'hFF};
      CPU_GUARD:
        if (!run_en || slot_done) state_nx = CPU_OWN;
        else slot_nx = slot_cnt + {7'd0, slot_cnt != 8'hFF};
      default: state_nx = CPU_OWN;
    endcase
  end
  // Without a beat the external side is forced to read so an idle grant never writes.
  always_comb begin
    ext_gnt = state == EXT_OWN;
    cpu_haltN = run_en & ~ext_gnt & ~reset;
    ram_address = ext_gnt ? ext_address : cpu_address;
    ram_wdata = ext_gnt ? ext_wdata : cpu_wdata;
    ram_readWriteN = ext_gnt ? (~ext_req | ext_readWriteN) : cpu_readWriteN;
    cpu_rdata = ram_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_rvalid <= 1'b0;
      ext_rdata <= '0;
    end else begin
      ext_rvalid <= beat & ext_readWriteN;
      if (beat & ext_readWriteN) ext_rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed self-checking bench for ram_bus_arbiter with a behavioural RAM.
module tb_ram_bus_arbiter;
  logic clk = 1'b0;
  logic reset, run_en, cpu_haltN, cpu_readWriteN, ext_req, ext_readWriteN;
  logic ext_gnt, ext_rvalid, ram_readWriteN, preload;
  logic [7:0] cpu_address, cpu_wdata, cpu_rdata, ext_address, ext_wdata, ext_rdata;
  logic [7:0] ram_address, ram_wdata, ram_rdata;
  logic [7:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  int cpu_i, ext_i;
  logic h, g;
  ram_bus_arbiter dut (
    .clk(clk), .reset(reset), .run_en(run_en), .cpu_haltN(cpu_haltN),
    .cpu_readWriteN(cpu_readWriteN), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .ext_req(ext_req), .ext_readWriteN(ext_readWriteN),
    .ext_address(ext_address), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ram_readWriteN(ram_readWriteN),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  // RAM image: mem[i] = i*7+3 after preload.
  always @(posedge clk)
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    else if (ram_readWriteN === 1'b0) mem[ram_address] <= ram_wdata;
  assign ram_rdata = mem[ram_address];
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  initial begin
    reset = 1; preload = 1; run_en = 1;
    cpu_readWriteN = 1; cpu_address = 8'h00; cpu_wdata = 8'h00;
    ext_req = 1; ext_readWriteN = 0; ext_address = 8'h10; ext_wdata = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      cyc;
      chk($sformatf("t1_gnt%0d", k), {7'd0, ext_gnt}, 8'd0);
      chk($sformatf("t1_halt%0d", k), {7'd0, cpu_haltN}, 8'd0);
      chk($sformatf("t1_rw%0d", k), {7'd0, ram_readWriteN}, 8'd1);
    end
    reset = 0; preload = 0; ext_req = 0;
    cyc;
    chk("idle_halt", {7'd0, cpu_haltN}, 8'd1);
    chk("idle_rvalid", {7'd0, ext_rvalid}, 8'd0);
    chk("idle_rdata", ext_rdata, 8'h00);
    ext_req = 1; ext_readWriteN = 0; ext_address = 8'h10; ext_wdata = 8'hA5;
    cyc;
    chk("t2_gnt", {7'd0, ext_gnt}, 8'd1);
    chk("t2_halt", {7'd0, cpu_haltN}, 8'd0);
    chk("t2_ram_addr", ram_address, 8'h10);
    chk("t2_ram_rw", {7'd0, ram_readWriteN}, 8'd0);
    cyc;
    chk("t2_mem10", mem[8'h10], 8'hA5);
    chk("t2_rvalid_wr", {7'd0, ext_rvalid}, 8'd0);
    ext_readWriteN = 1;
    cyc;
    chk("t2_rvalid", {7'd0, ext_rvalid}, 8'd1);
    chk("t2_rdata", ext_rdata, 8'hA5);
    ext_req = 0;
    cyc;
    chk("t2_release_gnt", {7'd0, ext_gnt}, 8'd0);
    chk("t2_release_rvalid", {7'd0, ext_rvalid}, 8'd0);
    chk("t2_release_halt", {7'd0, cpu_haltN}, 8'd1);
    chk("t2_hold_rdata", ext_rdata, 8'hA5);
    cpu_address = 8'h10;
    #1;
    chk("cpu_rdata", cpu_rdata, 8'hA5);
    ext_req = 1; ext_readWriteN = 1; ext_address = 8'h00;
    cyc;
    // 4 granted beats, 2 guard cycles, 1 CPU_OWN cycle for re-grant latency.
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("t3_gnt%0d", k), {7'd0, ext_gnt}, {7'd0, (k % 7) < 4});
      chk($sformatf("t3_halt%0d", k), {7'd0, cpu_haltN}, {7'd0, (k % 7) >= 4});
      if ((k % 7) >= 4) chk($sformatf("t3_nowr%0d", k), {7'd0, ram_readWriteN}, 8'd1);
      cyc;
    end
    ext_req = 0;
    cyc;
    cyc;
    run_en = 0; ext_req = 1; ext_readWriteN = 1;
    cyc;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t4_gnt%0d", k), {7'd0, ext_gnt}, 8'd1);
      chk($sformatf("t4_halt%0d", k), {7'd0, cpu_haltN}, 8'd0);
      cyc;
    end
    ext_req = 0;
    cyc;
    chk("t4_release_gnt", {7'd0, ext_gnt}, 8'd0);
    chk("t4_halt_run0", {7'd0, cpu_haltN}, 8'd0);
    run_en = 1;
    #1;
    chk("t4_halt_run1", {7'd0, cpu_haltN}, 8'd1);
    // CPU writes 0x80+i to 0x20+i, advancing only on edges where it was not halted.
    cpu_i = 0; ext_i = 0;
    cpu_readWriteN = 0; cpu_address = 8'h20; cpu_wdata = 8'h80;
    ext_req = 1; ext_readWriteN = 1; ext_address = 8'h00;
    for (int k = 0; k < 100 && (cpu_i < 8 || ext_i < 16); k++) begin
      h = cpu_haltN;
      g = ext_gnt;
      cyc;
      if (g && ext_req) begin
        chk($sformatf("t5_rvalid%0d", ext_i), {7'd0, ext_rvalid}, 8'd1);
        chk($sformatf("t5_rdata%0d", ext_i), ext_rdata, 8'(ext_i * 7 + 3));
        ext_i++;
        if (ext_i == 16) ext_req = 0;
        else ext_address = 8'(ext_i);
      end
      if (h && cpu_i < 8) begin
        cpu_i++;
        if (cpu_i == 8) cpu_readWriteN = 1;
        else begin
          cpu_address = 8'(32 + cpu_i);
          cpu_wdata = 8'(128 + cpu_i);
        end
      end
    end
    chk("t5_done", {7'd0, cpu_i == 8 && ext_i == 16}, 8'd1);
    ext_req = 0; cpu_readWriteN = 1;
    cyc;
    cyc;
    for (int i = 0; i < 8; i++) chk($sformatf("t5_mem%0d", i), mem[32 + i], 8'(128 + i));
    ext_req = 1; ext_readWriteN = 0; ext_address = 8'h30; ext_wdata = 8'h11;
    cyc;
    cyc;
    ext_address = 8'h31; ext_wdata = 8'h22; reset = 1;
    cyc;
    chk("t6_gnt", {7'd0, ext_gnt}, 8'd0);
    chk("t6_rvalid", {7'd0, ext_rvalid}, 8'd0);
    chk("t6_halt", {7'd0, cpu_haltN}, 8'd0);
    chk("t6_mem30", mem[8'h30], 8'h11);
    chk("t6_mem31", mem[8'h31], 8'h22);
    ext_address = 8'h32; ext_wdata = 8'h33; reset = 0;
    cyc;
    ext_req = 0;
    cyc;
    chk("t6_mem32", mem[8'h32], 8'h61);
    chk("t6_mem31_kept", mem[8'h31], 8'h22);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
